// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and a pending-write
// scoreboard; register 0 is hardwired to zero.
module regfile_mp_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int BYPASS     = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_WRITE-1:0]             wen,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  waddr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wdata,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rdata,
    output logic [NUM_READ-1:0]              rbusy,
    input  logic                             iss_valid,
    input  logic [ADDR_WIDTH-1:0]            iss_addr,
    input  logic [ADDR_WIDTH-1:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0]            dbg_data,
    output logic [DATA_WIDTH-1:0]            a0_value
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int A0_IDX = 10;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;

    // Later loop iterations override earlier ones, so the highest write port wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                    mem[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
                if (wen[k]) begin
                    busy[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
                end
            end
            // Issue is applied after the clears so a new producer supersedes a retiring one.
            if (iss_valid && (iss_addr != '0)) begin
                busy[iss_addr] <= 1'b1;
            end
            busy[0] <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;
        logic [DATA_WIDTH-1:0] fwd;

        assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            hit = 1'b0;
            fwd = mem[ra];
            for (int k = 0; k < NUM_WRITE; k++) begin
                if ((BYPASS != 0) && wen[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                    hit = 1'b1;
                    fwd = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 : fwd;
        assign rbusy[i] = busy[ra] & ~hit;
    end

    assign dbg_data = mem[dbg_addr];
    assign a0_value = mem[A0_IDX];

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with pending-write scoreboard, successor to the single-write/two-read RV32I register file.
- Serves the decode stage: N read ports with write-to-read bypass, plus per-read-port busy flags for hazard detection.
- Accepts M writeback ports. Register 0 is hardwired to zero.
- Exposes a0 and a debug read port for the trace/commit logic.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (1..4)
NUM_WRITE, 2, number of write ports (1..3)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high; clears array and scoreboard
wen  input  NUM_WRITE  per-port write enable
waddr  input  NUM_WRITE*ADDR_WIDTH  packed write indices, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
wdata  input  NUM_WRITE*DATA_WIDTH  packed write data
raddr  input  NUM_READ*ADDR_WIDTH  packed read indices
rdata  output  NUM_READ*DATA_WIDTH  packed read data (combinational)
rbusy  output  NUM_READ  per-read-port: indexed register has a pending write
iss_valid  input  1  issue of an instruction with a destination
iss_addr  input  ADDR_WIDTH  destination index being issued; sets busy
dbg_addr  input  ADDR_WIDTH  debug/trace read index
dbg_data  output  DATA_WIDTH  array value at dbg_addr (no bypass)
a0_value  output  DATA_WIDTH  array value of register 10 (no bypass)

Behaviour:
- Array: 2**ADDR_WIDTH x DATA_WIDTH flops. Entry 0 is never written and always reads 0.
- Writes: on rising edge with reset=0, each port k with wen[k]=1 and waddr!=0 writes wdata into array.
- Same-address multi-write: highest-index port wins (port NUM_WRITE-1 has top priority).
- Reads: rdata[i] = 0 if raddr[i]==0.
  - Else if BYPASS=1 and any enabled write port matches raddr[i], that port's wdata (highest index wins). Zero-cycle forwarding.
  - Else array[raddr[i]].
- dbg_data and a0_value read the array only; they reflect writes one cycle after the write edge.
- Scoreboard: busy vector, 2**ADDR_WIDTH bits; bit 0 constant 0.
  - Clear: on edge, each enabled write port clears busy[waddr].
  - Set: on edge, iss_valid with iss_addr!=0 sets busy[iss_addr].
  - Set and clear of the same register in the same cycle: set wins (a new producer supersedes the retiring one).
  - Write to a non-busy register: legal, no scoreboard change.
- rbusy[i] = busy[raddr[i]] & ~(BYPASS & any enabled write port matching raddr[i]). A bypassed value is not reported busy. rbusy[i]=0 for raddr[i]==0.
- Reset (synchronous, active-high): at the edge with reset=1, all array entries <= 0 and busy <= 0. Writes and issues in that cycle are discarded.
  - Combinational outputs during the reset cycle still follow the current inputs and state.
- After reset, with no writes pending: rdata=0, rbusy=0, dbg_data=0, a0_value=0.
- Reset asserted mid-stream: pending busy bits are lost. The issue logic must be flushed concurrently; no recovery behaviour in this block.
- No internal latency beyond one edge for array and scoreboard updates. All read paths are combinational.

Test Plan:
- Reset, then write port0 x5=0x0000_1234; read raddr0=5 same cycle -> rdata0=0x1234 (BYPASS=1), dbg_data(addr 5)=0 until next cycle, then 0x1234.
- Both ports write x7 same cycle: port0=0xAAAA_AAAA, port1=0x5555_5555 -> array x7=0x5555_5555; same-cycle read of x7 returns 0x5555_5555.
- Write x0=0xFFFF_FFFF and issue x0 -> raddr=0 gives 0, rbusy=0, dbg_data(0)=0.
- Issue x3; next cycle read x3 -> rbusy=1. Issue x3 again while port1 writes x3=0x42 the same cycle -> busy stays 1, array x3=0x42. Later write with no issue -> rbusy=0.
- Write x10=0xDEAD_BEEF -> a0_value=0xDEAD_BEEF one cycle later. Assert reset with a simultaneous write x10=1 -> a0_value=0 and all busy 0 after the edge.
- BYPASS=0 build: write x9=0x99 and read x9 same cycle -> rdata=old value (0); rbusy follows busy with no bypass masking.
